// File: rtl/xbar_pkg.sv
// Shared cross-bar encodings: command codes and the per-port arbiter states.
package xbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/order_fifo.sv
// In-order queue of master indices for reads accepted by the slave.
// The head is read combinationally so returning data is steered without latency.
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Round-robin share of one slave port between N masters, with read-data
// steering through an in-order queue of issuing master indices.
module slave_port_arbiter
  import xbar_pkg::*;
#(
  parameter int N     = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic [N-1:0]           master_req,
  input  logic [N-1:0]           master_cmd,
  input  logic [N*AW-1:0]        master_addr,
  input  logic [N*DW-1:0]        master_wdata,
  output logic [N-1:0]           master_ack,
  output logic [DW-1:0]          master_rdata,
  output logic [N-1:0]           master_rvalid,
  output logic                   slave_req,
  output logic                   slave_cmd,
  output logic [AW-1:0]          slave_addr,
  output logic [DW-1:0]          slave_wdata,
  input  logic                   slave_ack,
  input  logic [DW-1:0]          slave_rdata,
  input  logic                   slave_rvalid,
  output logic                   err_unexp,
  output logic [$clog2(DEPTH):0] rd_pending
);

  localparam int GW = $clog2(N);

  logic [AW-1:0] addr_arr  [N];
  logic [DW-1:0] wdata_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_arr[gi]  = master_addr[gi*AW +: AW];
    assign wdata_arr[gi] = master_wdata[gi*DW +: DW];
  end

  arb_state_t    state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] rr_reg, rr_next;
  logic          err_reg;
  logic          found;
  int            idx;
  logic          xfer;

  logic          fifo_push, fifo_full, fifo_empty;
  logic [GW-1:0] fifo_head;

  assign slave_cmd   = master_cmd[grant_reg];
  assign slave_addr  = addr_arr[grant_reg];
  assign slave_wdata = wdata_arr[grant_reg];

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    slave_req  = 1'b0;
    master_ack = '0;
    xfer       = 1'b0;
    found      = 1'b0;
    idx        = 0;
    case (state_reg)
      IDLE: begin
        if (|master_req) begin
          for (int k = 0; k < N; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= N) idx = idx - N;
            if (!found && master_req[idx]) begin
              found      = 1'b1;
              grant_next = GW'(idx);
            end
          end
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A read may only be forwarded when the order queue has room for it.
        slave_req = master_req[grant_reg] &&
                    !((master_cmd[grant_reg] == CMD_READ) && fifo_full);
        xfer = slave_req && slave_ack;
        if (xfer) begin
          master_ack[grant_reg] = 1'b1;
          rr_next    = (grant_reg == GW'(N-1)) ? '0 : grant_reg + GW'(1);
          state_next = IDLE;
        end else if (!master_req[grant_reg]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      rr_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
      if (slave_rvalid && fifo_empty) err_reg <= 1'b1;
    end
  end

  assign fifo_push = xfer && (slave_cmd == CMD_READ);

  order_fifo #(
    .DEPTH (DEPTH),
    .W     (GW)
  ) u_order_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (grant_reg),
    .pop       (slave_rvalid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rd_pending)
  );

  always_comb begin
    master_rvalid = '0;
    if (slave_rvalid && !fifo_empty) master_rvalid[fifo_head] = 1'b1;
  end

  assign master_rdata = slave_rdata;
  assign err_unexp    = err_reg;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed stimulus with a queue scoreboard; a negedge monitor checks every
// master_ack and master_rvalid event against the expected-response queues.
module tb_slave_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [1:0]  req, cmd;
  logic [63:0] addr, wdata;
  logic [1:0]  m_ack, m_rvalid;
  logic [31:0] m_rdata;
  logic        s_req, s_cmd;
  logic [31:0] s_addr, s_wdata;
  logic        sack;
  logic [31:0] srdata;
  logic        srvalid;
  logic        err;
  logic [2:0]  pending;

  int total = 0;
  int bad   = 0;

  logic [1:0]  exp_ack[$];
  logic [33:0] exp_rv[$];

  always #5 clk = ~clk;

  slave_port_arbiter #(.N(2), .AW(32), .DW(32), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .master_req    (req),
    .master_cmd    (cmd),
    .master_addr   (addr),
    .master_wdata  (wdata),
    .master_ack    (m_ack),
    .master_rdata  (m_rdata),
    .master_rvalid (m_rvalid),
    .slave_req     (s_req),
    .slave_cmd     (s_cmd),
    .slave_addr    (s_addr),
    .slave_wdata   (s_wdata),
    .slave_ack     (sack),
    .slave_rdata   (srdata),
    .slave_rvalid  (srvalid),
    .err_unexp     (err),
    .rd_pending    (pending)
  );

  // Monitor: every ack / rvalid event must match the head of its queue.
  always @(negedge clk) begin
    if (m_ack != 2'b00) begin
      total++;
      if (exp_ack.size() == 0) begin
        bad++;
        $display("FAIL ack_unexpected: got %b want none", m_ack);
      end else begin
        logic [1:0] e;
        e = exp_ack.pop_front();
        if (m_ack !== e) begin
          bad++;
          $display("FAIL ack: got %b want %b", m_ack, e);
        end else $display("ack ok master_ack=%b", m_ack);
      end
    end
    if (m_rvalid != 2'b00) begin
      total++;
      if (exp_rv.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected: got %b/%h want none", m_rvalid, m_rdata);
      end else begin
        logic [33:0] e;
        e = exp_rv.pop_front();
        if ({m_rvalid, m_rdata} !== e) begin
          bad++;
          $display("FAIL rvalid: got %b/%h want %b/%h", m_rvalid, m_rdata, e[33:32], e[31:0]);
        end else $display("rvalid ok master_rvalid=%b rdata=%h", m_rvalid, m_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One granted transfer of master m from IDLE; slave acks on the first BUSY cycle.
  task automatic do_xfer(input int m, input logic c, input logic [31:0] a, input logic [31:0] d);
    logic [1:0] oh;
    oh = 2'b01 << m;
    req[m] = 1'b1;
    cmd[m] = c;
    addr[m*32 +: 32]  = a;
    wdata[m*32 +: 32] = d;
    tick();
    sack = 1'b1;
    exp_ack.push_back(oh);
    check("xfer_req", 32'(s_req), 32'd1);
    check("xfer_addr", s_addr, a);
    if (c) check("xfer_wdata", s_wdata, d);
    tick();
    req[m] = 1'b0;
    sack   = 1'b0;
  endtask

  task automatic ret(input int m, input logic [31:0] d);
    logic [1:0] oh;
    oh = 2'b01 << m;
    srvalid = 1'b1;
    srdata  = d;
    exp_rv.push_back({oh, d});
    tick();
    srvalid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; req = '0; cmd = '0; addr = '0; wdata = '0;
    sack = 1'b0; srdata = '0; srvalid = 1'b0;
    tick();
    tick();
    check("rst_slave_req", 32'(s_req), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ack", 32'(m_ack), 32'd0);
    check("rst_rvalid", 32'(m_rvalid), 32'd0);
    rst_in = 1'b1;
    tick();

    // Single read from master 1
    check("single_pending0", 32'(pending), 32'd0);
    do_xfer(1, 1'b0, 32'h10, 32'h0);
    check("single_pending1", 32'(pending), 32'd1);
    tick();
    tick();
    ret(1, 32'hA5A5);
    check("single_pending2", 32'(pending), 32'd0);

    // Contention: continuous writes from both masters, slave always ready
    req = 2'b11; cmd = 2'b11;
    addr = {32'h200, 32'h100}; wdata = {32'hBBBB, 32'hAAAA};
    sack = 1'b1;
    for (int k = 0; k < 8; k++) exp_ack.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("contend_req", 32'(s_req), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0)
        check("contend_wdata", s_wdata, (k % 4 == 0) ? 32'hAAAA : 32'hBBBB);
    end
    req = 2'b00; sack = 1'b0;
    tick();

    // Ordering: m0, m1, m1, m0
    do_xfer(0, 1'b0, 32'h20, 32'h0);
    do_xfer(1, 1'b0, 32'h24, 32'h0);
    do_xfer(1, 1'b0, 32'h28, 32'h0);
    do_xfer(0, 1'b0, 32'h2C, 32'h0);
    check("order_pending", 32'(pending), 32'd4);
    ret(0, 32'hD0);
    ret(1, 32'hD1);
    ret(1, 32'hD2);
    ret(0, 32'hD3);
    check("order_drained", 32'(pending), 32'd0);

    // Full queue
    do_xfer(0, 1'b0, 32'h30, 32'h0);
    do_xfer(1, 1'b0, 32'h34, 32'h0);
    do_xfer(0, 1'b0, 32'h38, 32'h0);
    do_xfer(1, 1'b0, 32'h3C, 32'h0);
    check("full_pending", 32'(pending), 32'd4);
    req[0] = 1'b1; cmd[0] = 1'b0; addr[31:0] = 32'h40;
    tick();
    sack = 1'b1;
    check("full_blocked", 32'(s_req), 32'd0);
    tick();
    check("full_blocked_hold", 32'(s_req), 32'd0);
    tick();
    srvalid = 1'b1; srdata = 32'hE0;
    exp_rv.push_back({2'b01, 32'hE0});
    check("full_pop_blocked", 32'(s_req), 32'd0);
    tick();
    srvalid = 1'b0;
    exp_ack.push_back(2'b01);
    check("full_released", 32'(s_req), 32'd1);
    check("full_released_addr", s_addr, 32'h40);
    tick();
    req[0] = 1'b0; sack = 1'b0;
    check("full_pending2", 32'(pending), 32'd4);
    do_xfer(1, 1'b1, 32'h50, 32'h5555);
    ret(1, 32'hE1);
    ret(0, 32'hE2);
    ret(1, 32'hE3);
    ret(0, 32'hE4);
    check("full_drained", 32'(pending), 32'd0);

    // Unexpected read data
    check("err_before", 32'(err), 32'd0);
    srvalid = 1'b1; srdata = 32'hBAD;
    check("err_no_rvalid", 32'(m_rvalid), 32'd0);
    tick();
    srvalid = 1'b0;
    check("err_set", 32'(err), 32'd1);
    tick();
    tick();
    check("err_sticky", 32'(err), 32'd1);

    // Reset mid-operation with reads outstanding
    do_xfer(0, 1'b0, 32'h60, 32'h0);
    do_xfer(1, 1'b0, 32'h64, 32'h0);
    do_xfer(0, 1'b0, 32'h68, 32'h0);
    req[1] = 1'b1; cmd[1] = 1'b0;
    tick();
    check("mid_req_before", 32'(s_req), 32'd1);
    rst_in = 1'b0;
    #1;
    check("mid_pending", 32'(pending), 32'd0);
    check("mid_slave_req", 32'(s_req), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    tick();
    check("mid_slave_req_held", 32'(s_req), 32'd0);
    check("mid_ack_held", 32'(m_ack), 32'd0);
    req = 2'b00;
    rst_in = 1'b1;
    tick();
    do_xfer(1, 1'b1, 32'h70, 32'h7777);
    check("post_pending", 32'(pending), 32'd0);
    tick();

    total++;
    if (exp_ack.size() != 0 || exp_rv.size() != 0) begin
      bad++;
      $display("FAIL leftover: got ack=%0d rv=%0d want 0", exp_ack.size(), exp_rv.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
